matrix_mult_seq: RTL and testbench

MATRIX_MULT_SEQ -- requirements
Module: matrix_mult_seq

---
 rtl/matrix_mult_seq.sv | 156 +++++++++++++++
 tb/tb_matrix_mult_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_seq.sv
// Sequential NxN matrix multiplier (C = A*B or C = C_prev + A*B) built around one
// multiplier, doing one multiply-accumulate per cycle in i/j/k order (k innermost).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request a new multiply (ignored while busy)
//   signed_mode  two's-complement operands/results when 1, unsigned when 0
//   acc_mode     1: C = C_prev + A*B, 0: C = A*B
//   a_flat       matrix A, row-major, DW bits per element
//   b_flat       matrix B, row-major, DW bits per element
//   c_flat       matrix C, row-major, CW bits per element
//   busy         high while computing
//   done         high from completion until the next accepted start or reset
//   overflow     sticky: some C write of the last operation wrapped
module matrix_mult_seq #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          signed_mode,
  input  logic                          acc_mode,
  input  logic [N*N*DW-1:0]             a_flat,
  input  logic [N*N*DW-1:0]             b_flat,
  output logic [N*N*(2*DW+$clog2(N))-1:0] c_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  localparam int unsigned CW = 2 * DW + $clog2(N);
  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] Last = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [N*N*DW-1:0]   a_q, a_d, b_q, b_d;
  logic                sgn_q, sgn_d, accm_q, accm_d;
  logic [IW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic [N*N*CW-1:0]   c_q, c_d;
  logic                ovf_q, ovf_d;

  int unsigned         a_idx, b_idx, c_idx;
  logic [DW-1:0]       a_el, b_el;
  logic [CW-1:0]       a_ext, b_ext, prod, sum, base, total;
  logic                carry, wr_ovf;

  // MAC datapath: operands are extended to CW first so the CW-bit product is
  // already the correctly wrapped signed or unsigned result.
  always_comb begin
    a_idx  = (int'(i_q) * N + int'(k_q)) * DW;
    b_idx  = (int'(k_q) * N + int'(j_q)) * DW;
    c_idx  = (int'(i_q) * N + int'(j_q)) * CW;
    a_el   = a_q[a_idx +: DW];
    b_el   = b_q[b_idx +: DW];
    a_ext  = sgn_q ? {{(CW-DW){a_el[DW-1]}}, a_el} : {{(CW-DW){1'b0}}, a_el};
    b_ext  = sgn_q ? {{(CW-DW){b_el[DW-1]}}, b_el} : {{(CW-DW){1'b0}}, b_el};
    prod   = a_ext * b_ext;
    sum    = acc_q + prod;
    base   = accm_q ? c_q[c_idx +: CW] : '0;
    {carry, total} = {1'b0, base} + {1'b0, sum};
    // Overflow is judged only on the final C write (base + dot product).
    wr_ovf = sgn_q ? ((base[CW-1] == sum[CW-1]) && (total[CW-1] != base[CW-1])) : carry;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    accm_d  = accm_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StBusy;
          a_d     = a_flat;
          b_d     = b_flat;
          sgn_d   = signed_mode;
          accm_d  = acc_mode;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StBusy: begin
        if (k_q == Last) begin
          c_d[c_idx +: CW] = total;
          acc_d = '0;
          ovf_d = ovf_q | wr_ovf;
          k_d   = '0;
          if (j_q == Last) begin
            j_d = '0;
            if (i_q == Last) begin
              i_d     = '0;
              state_d = StDone;
            end else begin
              i_d = i_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          k_d   = k_q + 1'b1;
          acc_d = sum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      accm_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      accm_q  <= accm_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign c_flat   = c_q;
  assign busy     = (state_q == StBusy);
  assign done     = (state_q == StDone);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_matrix_mult_seq.sv
// Self-checking bench for matrix_mult_seq (N=3, DW=8). A behavioural model steps on
// every falling edge and is compared with all DUT outputs; directed cases pin the
// model with hand-computed results, then randomized operations follow.
module tb_matrix_mult_seq;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int CW = 2 * DW + $clog2(N);
  localparam int NE = N * N;
  localparam int FW = NE * CW;
  localparam int OPS = N * N * N;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            signed_mode = 1'b0;
  logic            acc_mode = 1'b0;
  logic [NE*DW-1:0] a_flat = '0;
  logic [NE*DW-1:0] b_flat = '0;
  logic [FW-1:0]   c_flat;
  logic            busy, done, overflow;

  matrix_mult_seq #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .acc_mode   (acc_mode),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .c_flat     (c_flat),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_busy, m_done, m_ovf;
  int            m_cnt;
  logic [CW-1:0] m_c[NE];
  logic [CW-1:0] m_new[NE];
  bit            m_eovf[NE];

  function automatic longint val(input logic [DW-1:0] x, input bit sgn);
    if (sgn) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic longint cval(input logic [CW-1:0] x, input bit sgn);
    if (sgn) return longint'($signed(x));
    return longint'(x);
  endfunction

  // Inputs only change just after a falling edge, so here they still hold the values
  // the DUT sampled on the preceding rising edge.
  always @(negedge clk) begin
    logic [FW-1:0] exp_c;
    if (reset) begin
      m_busy = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
      for (int e = 0; e < NE; e++) m_c[e] = '0;
    end else if (!m_busy && start) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          longint dot, tot, base;
          dot = 0;
          for (int k = 0; k < N; k++)
            dot += val(a_flat[(i*N+k)*DW +: DW], signed_mode) *
                   val(b_flat[(k*N+j)*DW +: DW], signed_mode);
          base = acc_mode ? cval(m_c[i*N+j], signed_mode) : 0;
          tot  = base + dot;
          m_new[i*N+j] = tot[CW-1:0];
          if (signed_mode)
            m_eovf[i*N+j] = (tot < -(longint'(1) << (CW-1))) || (tot >= (longint'(1) << (CW-1)));
          else
            m_eovf[i*N+j] = (tot >= (longint'(1) << CW));
        end
      end
      m_busy = 1; m_done = 0; m_ovf = 0; m_cnt = 0;
    end else if (m_busy) begin
      m_cnt++;
      // Element e is finished after its N products, i.e. after (e+1)*N MACs.
      for (int e = 0; e < NE; e++) begin
        if ((e + 1) * N == m_cnt) begin
          m_c[e] = m_new[e];
          m_ovf  = m_ovf | m_eovf[e];
        end
      end
      if (m_cnt == OPS) begin
        m_busy = 0;
        m_done = 1;
      end
    end
    for (int e = 0; e < NE; e++) exp_c[e*CW +: CW] = m_c[e];
    check("busy", FW'(busy), FW'(m_busy));
    check("done", FW'(done), FW'(m_done));
    check("overflow", FW'(overflow), FW'(m_ovf));
    check("c_flat", c_flat, exp_c);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] elem(input int e);
    return c_flat[e*CW +: CW];
  endfunction

  task automatic check_elems(input string name, input logic [CW-1:0] exp[NE]);
    for (int e = 0; e < NE; e++) check(name, FW'(elem(e)), FW'(exp[e]));
  endtask

  // Start one operation, scramble all inputs while busy (optionally pulsing start at
  // cycle 'glitch'), wait for done and restore the inputs afterwards.
  task automatic run(input bit sgn, input bit accm, input int glitch);
    logic [NE*DW-1:0] sa, sb;
    int lat;
    sa = a_flat; sb = b_flat;
    signed_mode = sgn;
    acc_mode    = accm;
    start       = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 200) begin
      tick();
      lat++;
      for (int e = 0; e < NE; e++) begin
        a_flat[e*DW +: DW] = DW'($urandom);
        b_flat[e*DW +: DW] = DW'($urandom);
      end
      signed_mode = 1'($urandom);
      acc_mode    = 1'($urandom);
      start       = (lat == glitch);
    end
    start = 1'b0;
    check("latency", FW'(lat), FW'(OPS));
    a_flat = sa; b_flat = sb; signed_mode = sgn; acc_mode = accm;
  endtask

  logic [CW-1:0] exp_v[NE];
  int            done_cnt;

  initial begin
    repeat (3) tick();
    check("reset_c", c_flat, '0);
    check("reset_busy", FW'(busy), '0);
    check("reset_done", FW'(done), '0);
    check("reset_ovf", FW'(overflow), '0);
    reset = 1'b0;
    tick();

    // A = 1..9, B = 9..1 unsigned
    for (int e = 0; e < NE; e++) begin
      a_flat[e*DW +: DW] = DW'(e + 1);
      b_flat[e*DW +: DW] = DW'(9 - e);
    end
    run(0, 0, -1);
    exp_v = '{18'd30, 18'd24, 18'd18, 18'd84, 18'd69, 18'd54, 18'd138, 18'd114, 18'd90};
    check_elems("c_seq", exp_v);
    check("ovf_seq", FW'(overflow), '0);

    // all 255 unsigned, then accumulate onto itself
    a_flat = '1; b_flat = '1;
    run(0, 0, -1);
    for (int e = 0; e < NE; e++) exp_v[e] = 18'd195075;
    check_elems("c_max", exp_v);
    check("ovf_max", FW'(overflow), '0);
    run(0, 1, -1);
    for (int e = 0; e < NE; e++) exp_v[e] = 18'd128006;
    check_elems("c_max_acc", exp_v);
    check("ovf_max_acc", FW'(overflow), FW'(1));

    // signed: -1 * 2 summed three times
    for (int e = 0; e < NE; e++) begin
      a_flat[e*DW +: DW] = 8'hFF;
      b_flat[e*DW +: DW] = 8'd2;
    end
    run(1, 0, -1);
    for (int e = 0; e < NE; e++) exp_v[e] = 18'h3FFFA;
    check_elems("c_signed", exp_v);

    // identity * B, then accumulate
    for (int e = 0; e < NE; e++) begin
      a_flat[e*DW +: DW] = (e / N == e % N) ? 8'd1 : 8'd0;
      b_flat[e*DW +: DW] = DW'(e + 2);
    end
    run(0, 0, -1);
    run(0, 1, -1);
    for (int e = 0; e < NE; e++) exp_v[e] = CW'(2 * (e + 2));
    check_elems("c_ident_acc", exp_v);

    // start pulse at cycle 5 with different A is ignored
    for (int e = 0; e < NE; e++) begin
      a_flat[e*DW +: DW] = DW'(e + 1);
      b_flat[e*DW +: DW] = DW'(9 - e);
    end
    run(0, 0, 5);
    exp_v = '{18'd30, 18'd24, 18'd18, 18'd84, 18'd69, 18'd54, 18'd138, 18'd114, 18'd90};
    check_elems("c_ignored_start", exp_v);

    // reset mid-operation
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_c", c_flat, '0);
    check("midrst_busy", FW'(busy), '0);
    check("midrst_done", FW'(done), '0);
    repeat (30) tick();
    check("midrst_done_later", FW'(done), '0);

    // reset together with start after a nonzero result
    run(0, 0, -1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rststart_c", c_flat, '0);
    check("rststart_busy", FW'(busy), '0);
    tick();
    check("rststart_busy2", FW'(busy), '0);

    // back-to-back: start held high restarts at every completion
    for (int e = 0; e < NE; e++) begin
      a_flat[e*DW +: DW] = DW'($urandom);
      b_flat[e*DW +: DW] = DW'($urandom);
    end
    start    = 1'b1;
    done_cnt = 0;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (done) done_cnt++;
    end
    start = 1'b0;
    check("b2b_done_cycles", FW'(done_cnt), FW'(2));
    for (int t = 0; t < 40 && !done; t++) tick();
    check("b2b_final_done", FW'(done), FW'(1));

    // randomized operations
    for (int n = 0; n < 15; n++) begin
      for (int e = 0; e < NE; e++) begin
        a_flat[e*DW +: DW] = DW'($urandom);
        b_flat[e*DW +: DW] = DW'($urandom);
      end
      run(1'($urandom), 1'($urandom), int'($urandom_range(1, 20)));
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
